dmem_responder: RTL and testbench

- Memory-side responder for the processor's data-memory interface; it serves MemRead/MemWrite requests issued by the multicycle core.
- It holds a word-addressed data store, inserts a programmable number of wait states, and returns read data with a one-cycle ready pulse.
- It flags illegal requests: misaligned, out of range, or read and write asserted together.
- It sits between the core's dAddress/dWriteData/MemRead/MemWrite outputs and its dReadData input.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_word_array.sv | 44 ++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: FSM states, error causes, index width.
// Pure declarations; no timing or flow-control behaviour of its own.
package dmem_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_DRAIN  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CONFLICT = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_RANGE    = 2'd3
    } err_cause_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH x 32 single-port RAM; write and registered read both take effect on the clock edge.
// dout holds its value between reads, so the last read word stays visible to the core.
module dmem_word_array #(
    parameter int DEPTH = 128,
    parameter int IW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];
    logic [31:0] dout_d;
    logic [31:0] dout_q;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (re) begin
            dout_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: legal request answers WAIT_STATES+2 cycles after sampling, illegal after 1.
// No backpressure; requests are only sampled in IDLE and a held level is absorbed in DRAIN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 128,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int          IW        = idx_width(DEPTH);
    localparam logic [31:0] END_ADDR  = BASE_ADDR + 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_e      state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    logic [IW-1:0] idx_d, idx_q;
    logic [31:0] wdata_d, wdata_q;
    logic        is_wr_d, is_wr_q;
    logic        mem_ready_d, mem_ready_q;
    logic        mem_err_d, mem_err_q;
    logic        mem_busy_d, mem_busy_q;
    logic        ram_we, ram_re;
    logic        req;
    err_cause_e  cause;

    assign req = MemRead | MemWrite;

    always_comb begin
        cause = ERR_NONE;
        if (MemRead && MemWrite) begin
            cause = ERR_CONFLICT;
        end else if (dAddress[1:0] != 2'b00) begin
            cause = ERR_MISALIGN;
        end else if ((dAddress < BASE_ADDR) || (dAddress >= END_ADDR)) begin
            cause = ERR_RANGE;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        mem_err_d = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = IW'((dAddress - BASE_ADDR) >> 2);
                    wdata_d = dWriteData;
                    is_wr_d = MemWrite;
                    if (cause != ERR_NONE) begin
                        state_d   = S_RESP;
                        mem_err_d = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                ram_we  = is_wr_q;
                ram_re  = ~is_wr_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A level request must drop before the next one can be taken.
                if (!MemRead && !MemWrite) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        mem_ready_d = (state_d == S_RESP);
        mem_busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            mem_busy_q  <= mem_busy_d;
        end
    end

    dmem_word_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (idx_q),
        .din  (wdata_q),
        .dout (dReadData)
    );

    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign mem_busy  = mem_busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic        rd_a, wr_a;
    logic [31:0] addr_a, wdata_a;
    logic [31:0] rdata_a;
    logic        ready_a, err_a, busy_a;

    logic        rd_b, wr_b;
    logic [31:0] addr_b, wdata_b;
    logic [31:0] rdata_b;
    logic        ready_b, err_b, busy_b;

    int n_checks;
    int n_errors;
    int lat;
    int pulses;
    logic err_seen;

    dmem_responder #(.DEPTH(128), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (rd_a),
        .MemWrite   (wr_a),
        .dAddress   (addr_a),
        .dWriteData (wdata_a),
        .dReadData  (rdata_a),
        .mem_ready  (ready_a),
        .mem_err    (err_a),
        .mem_busy   (busy_a)
    );

    dmem_responder #(.DEPTH(128), .BASE_ADDR(32'h1001_0000), .WAIT_STATES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (rd_b),
        .MemWrite   (wr_b),
        .dAddress   (addr_b),
        .dWriteData (wdata_b),
        .dReadData  (rdata_b),
        .mem_ready  (ready_b),
        .mem_err    (err_b),
        .mem_busy   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
        end
    endtask

    // Issue a request held for 'hold' sampling edges, then watch 'window' cycles.
    // lat is the cycle (1 = first cycle after the sampling edge) of the first ready.
    task automatic run_req(input bit sel, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input int hold, input int window,
                           output int o_lat, output int o_pulses, output logic o_err);
        logic rdy;
        drive(sel, rd, wr, a, d);
        o_lat = 0;
        o_pulses = 0;
        o_err = 1'b0;
        for (int c = 1; c <= window; c++) begin
            @(posedge clk);
            #1;
            if (c == hold) drive(sel, 1'b0, 1'b0, a ^ 32'hFFFF_0000, ~d);
            rdy = sel ? ready_b : ready_a;
            if (rdy) begin
                o_pulses++;
                if (o_lat == 0) begin
                    o_lat = c;
                    o_err = sel ? err_b : err_a;
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #22;
        chk("rst_rdata", rdata_a, 32'h0);
        chk("rst_ready", {31'b0, ready_a}, 32'h0);
        chk("rst_err", {31'b0, err_a}, 32'h0);
        chk("rst_busy", {31'b0, busy_a}, 32'h0);
        chk("rst_ready0", {31'b0, ready_b}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Write then read back with two wait states
        run_req(1'b0, 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1, 30, lat, pulses, err_seen);
        chk("wr_lat", lat, 4);
        chk("wr_err", {31'b0, err_seen}, 32'h0);
        chk("wr_pulses", pulses, 1);
        chk("wr_rdata_kept", rdata_a, 32'h0);
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("rd_lat", lat, 4);
        chk("rd_err", {31'b0, err_seen}, 32'h0);
        chk("rd_data", rdata_a, 32'hDEAD_BEEF);
        chk("idle_busy", {31'b0, busy_a}, 32'h0);

        // Last legal word
        run_req(1'b0, 1'b0, 1'b1, 32'h1001_01FC, 32'h0BAD_F00D, 1, 30, lat, pulses, err_seen);
        chk("top_wr_err", {31'b0, err_seen}, 32'h0);
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_01FC, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("top_rd_lat", lat, 4);
        chk("top_rd_err", {31'b0, err_seen}, 32'h0);
        chk("top_rd_data", rdata_a, 32'h0BAD_F00D);

        // Illegal requests answer one cycle after sampling
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_0200, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("oor_lat", lat, 1);
        chk("oor_err", {31'b0, err_seen}, 32'h1);
        chk("oor_rdata_kept", rdata_a, 32'h0BAD_F00D);
        chk("err_low_idle", {31'b0, err_a}, 32'h0);
        run_req(1'b0, 1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("below_lat", lat, 1);
        chk("below_err", {31'b0, err_seen}, 32'h1);
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_0002, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("mis_lat", lat, 1);
        chk("mis_err", {31'b0, err_seen}, 32'h1);
        run_req(1'b0, 1'b1, 1'b1, 32'h1001_0004, 32'h1111_1111, 1, 30, lat, pulses, err_seen);
        chk("conf_lat", lat, 1);
        chk("conf_err", {31'b0, err_seen}, 32'h1);
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("conf_readback", rdata_a, 32'hDEAD_BEEF);

        // Held level read: one response only, then a fresh read is accepted
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_01FC, 32'h0, 10, 30, lat, pulses, err_seen);
        chk("held_lat", lat, 4);
        chk("held_pulses", pulses, 1);
        chk("held_data", rdata_a, 32'h0BAD_F00D);
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("after_held_lat", lat, 4);
        chk("after_held_data", rdata_a, 32'hDEAD_BEEF);

        // Zero wait states, back-to-back pulses one DRAIN cycle apart
        run_req(1'b1, 1'b0, 1'b1, 32'h1001_0010, 32'hCAFE_0000, 1, 4, lat, pulses, err_seen);
        chk("ws0_wr_lat", lat, 2);
        chk("ws0_wr_pulses", pulses, 1);
        run_req(1'b1, 1'b1, 1'b0, 32'h1001_0010, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("ws0_rd_lat", lat, 2);
        chk("ws0_rd_pulses", pulses, 1);
        chk("ws0_rd_data", rdata_b, 32'hCAFE_0000);

        // Reset during WAIT aborts a write
        run_req(1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'hA5A5_A5A5, 1, 30, lat, pulses, err_seen);
        chk("pre_wr_lat", lat, 4);
        drive(1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'h1234_5678);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_busy", {31'b0, busy_a}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_rdata", rdata_a, 32'h0);
        chk("abort_ready", {31'b0, ready_a}, 32'h0);
        chk("abort_busy0", {31'b0, busy_a}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ready_a) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        run_req(1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'h0, 1, 30, lat, pulses, err_seen);
        chk("abort_rd_lat", lat, 4);
        chk("abort_rd_data", rdata_a, 32'hA5A5_A5A5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
